// File: rtl/ucsbece154_icache_cwf.sv
// Set-associative instruction cache with critical-word-first refill,
// early restart, true LRU replacement, whole-cache flush and saturating
// hit/miss counters.
//
// state | meaning
// IDLE  | accepting fetches; hits answered next cycle, misses start a refill
// FILL  | burst refill in progress; fetches ignored until the last word lands
module ucsbece154_icache_cwf #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_SIZE   = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic                 ReadEnable,
    input  logic [31:0]          ReadAddress,
    input  logic                 Flush,
    output logic [WORD_SIZE-1:0] Instruction,
    output logic                 Ready,
    output logic                 Busy,
    output logic [31:0]          MemReadAddress,
    output logic                 MemReadRequest,
    input  logic [31:0]          MemDataIn,
    input  logic                 MemDataReady,
    output logic [CNT_WIDTH-1:0] HitCount,
    output logic [CNT_WIDTH-1:0] MissCount
);

    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int OFF    = 2 + WORD_W;
    localparam int TAG_W  = 32 - OFF - SET_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, state_next;

    logic [WORD_SIZE-1:0] data_mem [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid    [NUM_SETS];
    logic [WAY_W-1:0]     age      [NUM_SETS][NUM_WAYS];

    logic [WORD_W-1:0] req_off;
    logic [SET_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic              unused_addr_bits;

    logic [SET_W-1:0]  fill_set;
    logic [TAG_W-1:0]  fill_tag;
    logic [WORD_W-1:0] fill_off;
    logic [WAY_W-1:0]  fill_way;
    logic [WORD_W-1:0] beat_cnt;
    logic [WORD_W-1:0] fill_idx;
    logic              flush_pending;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;

    logic hit_access, start_miss, flush_now, beat, last_beat, apply_flush;

    assign req_off          = ReadAddress[OFF-1:2];
    assign req_set          = ReadAddress[OFF+SET_W-1:OFF];
    assign req_tag          = ReadAddress[31:OFF+SET_W];
    assign unused_addr_bits = ^ReadAddress[1:0];
    assign fill_idx         = fill_off + beat_cnt;
    assign apply_flush      = flush_now | (last_beat & (flush_pending | Flush));

    // New age of one way when way 'ref_age' is promoted to MRU.
    function automatic logic [WAY_W-1:0] aged(input logic [WAY_W-1:0] cur,
                                              input logic [WAY_W-1:0] ref_age,
                                              input logic             is_self);
        if (is_self)
            return '0;
        else if (cur < ref_age)
            return cur + WAY_W'(1);
        else
            return cur;
    endfunction

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[req_set][w] && tag_mem[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the oldest way.
    always_comb begin
        victim = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age[req_set][w] == WAY_W'(NUM_WAYS - 1))
                victim = WAY_W'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[req_set][w])
                victim = WAY_W'(w);
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and per-cycle action strobes.
    always_comb begin
        state_next = state;
        hit_access = 1'b0;
        start_miss = 1'b0;
        flush_now  = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        case (state)
            IDLE: begin
                if (Flush) begin
                    flush_now = 1'b1;
                end else if (ReadEnable) begin
                    if (hit) begin
                        hit_access = 1'b1;
                    end else begin
                        start_miss = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (MemDataReady) begin
                    beat = 1'b1;
                    if (beat_cnt == WORD_W'(BLOCK_WORDS - 1)) begin
                        last_beat  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs, valid/LRU bookkeeping, refill context and counters.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            Instruction    <= '0;
            Ready          <= 1'b0;
            Busy           <= 1'b0;
            MemReadAddress <= '0;
            MemReadRequest <= 1'b0;
            HitCount       <= '0;
            MissCount      <= '0;
            fill_set       <= '0;
            fill_tag       <= '0;
            fill_off       <= '0;
            fill_way       <= '0;
            beat_cnt       <= '0;
            flush_pending  <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++)
                    age[s][w] <= WAY_W'(w);
            end
        end else begin
            Ready <= 1'b0;

            if (hit_access) begin
                Instruction <= data_mem[req_set][hit_way][req_off];
                Ready       <= 1'b1;
                if (HitCount != {CNT_WIDTH{1'b1}})
                    HitCount <= HitCount + CNT_WIDTH'(1);
                for (int w = 0; w < NUM_WAYS; w++)
                    age[req_set][w] <= aged(age[req_set][w], age[req_set][hit_way],
                                            hit_way == WAY_W'(w));
            end

            if (start_miss) begin
                Busy                    <= 1'b1;
                MemReadRequest          <= 1'b1;
                MemReadAddress          <= {ReadAddress[31:2], 2'b00};
                fill_set                <= req_set;
                fill_tag                <= req_tag;
                fill_off                <= req_off;
                fill_way                <= victim;
                beat_cnt                <= '0;
                flush_pending           <= 1'b0;
                valid[req_set][victim]  <= 1'b0;
                if (MissCount != {CNT_WIDTH{1'b1}})
                    MissCount <= MissCount + CNT_WIDTH'(1);
            end

            if (state == FILL && Flush)
                flush_pending <= 1'b1;

            if (beat) begin
                beat_cnt <= beat_cnt + WORD_W'(1);
                if (beat_cnt == '0) begin
                    Instruction <= MemDataIn;
                    Ready       <= 1'b1;
                end
            end

            if (last_beat) begin
                Busy           <= 1'b0;
                MemReadRequest <= 1'b0;
                flush_pending  <= 1'b0;
                if (!apply_flush) begin
                    valid[fill_set][fill_way] <= 1'b1;
                    for (int w = 0; w < NUM_WAYS; w++)
                        age[fill_set][w] <= aged(age[fill_set][w], age[fill_set][fill_way],
                                                 fill_way == WAY_W'(w));
                end
            end

            // A flush (immediate or deferred to the end of a refill) wins
            // over any valid/age update made above in the same cycle.
            if (apply_flush) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid[s] <= '0;
                    for (int w = 0; w < NUM_WAYS; w++)
                        age[s][w] <= WAY_W'(w);
                end
            end
        end
    end

    // Line data and tag storage; written only by refill beats.
    always_ff @(posedge Clk) begin
        if (beat)
            data_mem[fill_set][fill_way][fill_idx] <= MemDataIn;
        if (last_beat)
            tag_mem[fill_set][fill_way] <= fill_tag;
    end

endmodule

// File: tb/tb_ucsbece154_icache_cwf.sv
// Bench for ucsbece154_icache_cwf: expected instructions are queued when a
// fetch is issued and popped whenever the cache raises Ready.
module tb_ucsbece154_icache_cwf;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          ResetN = 1'b0;
    logic          ReadEnable = 1'b0;
    logic [31:0]   ReadAddress = '0;
    logic          Flush = 1'b0;
    logic [31:0]   Instruction;
    logic          Ready;
    logic          Busy;
    logic [31:0]   MemReadAddress;
    logic          MemReadRequest;
    logic [31:0]   MemDataIn = '0;
    logic          MemDataReady = 1'b0;
    logic [CW-1:0] HitCount;
    logic [CW-1:0] MissCount;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] exp_q[$];

    ucsbece154_icache_cwf #(.CNT_WIDTH(CW)) dut (
        .Clk(Clk), .ResetN(ResetN), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
        .Flush(Flush), .Instruction(Instruction), .Ready(Ready), .Busy(Busy),
        .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
        .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h100)
            return 32'hA0 + {28'b0, a[3:2]};
        else
            return {a[31:2], 2'b10};
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Scoreboard consumer: every Ready must match the oldest expected word.
    always @(posedge Clk) begin
        #2;
        if (Ready) begin
            if (exp_q.size() == 0)
                check("spurious_ready", Ready, 1'b0);
            else
                check("instr", Instruction, exp_q.pop_front());
        end
    end

    // Memory side of a refill: wrap order from the critical word, one stall
    // before the second beat, optional Flush on beat flush_beat.
    task automatic burst(input logic [31:0] addr, input int flush_beat);
        logic [1:0] o;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                MemDataReady = 1'b0;
                @(negedge Clk);
                check("stall_busy", Busy, 1'b1);
            end
            o = addr[3:2] + 2'(k);
            MemDataReady = 1'b1;
            MemDataIn    = mem_word({addr[31:4], o, 2'b00});
            Flush        = (k == flush_beat);
            @(negedge Clk);
        end
        MemDataReady = 1'b0;
        MemDataIn    = '0;
        Flush        = 1'b0;
        check("fill_done_busy", Busy, 1'b0);
        check("fill_done_req", MemReadRequest, 1'b0);
    endtask

    task automatic access(input logic [31:0] addr, input bit exp_hit, input int flush_beat);
        @(negedge Clk);
        ReadEnable  = 1'b1;
        ReadAddress = addr;
        exp_q.push_back(mem_word(addr));
        @(negedge Clk);
        ReadEnable = 1'b0;
        if (exp_hit) begin
            exp_hits = sat(exp_hits);
            check("hit_busy", Busy, 1'b0);
            check("hit_req", MemReadRequest, 1'b0);
        end else begin
            exp_misses = sat(exp_misses);
            check("miss_busy", Busy, 1'b1);
            check("miss_req", MemReadRequest, 1'b1);
            check("miss_addr", MemReadAddress, {addr[31:2], 2'b00});
            burst(addr, flush_beat);
        end
        check("ready_seen", exp_q.size(), 0);
        check("hit_cnt", HitCount, exp_hits);
        check("miss_cnt", MissCount, exp_misses);
    endtask

    initial begin
        logic [31:0] b2b [3];
        b2b[0] = 32'h1000; b2b[1] = 32'h1004; b2b[2] = 32'h100C;

        repeat (2) @(negedge Clk);
        check("rst_ready", Ready, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_req", MemReadRequest, 1'b0);
        check("rst_addr", MemReadAddress, 32'h0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_hits", HitCount, 0);
        check("rst_misses", MissCount, 0);
        ResetN = 1'b1;

        // Critical-word-first miss
        access(32'h1008, 1'b0, -1);

        // Back-to-back hits on the remaining words of the line
        @(negedge Clk);
        ReadEnable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ReadAddress = b2b[i];
            exp_q.push_back(mem_word(b2b[i]));
            exp_hits = sat(exp_hits);
            @(negedge Clk);
            check("b2b_req", MemReadRequest, 1'b0);
        end
        ReadEnable = 1'b0;
        check("b2b_ready_seen", exp_q.size(), 0);
        check("b2b_hits", HitCount, exp_hits);

        // Stray MemDataReady in IDLE does nothing
        MemDataReady = 1'b1;
        MemDataIn    = 32'hDEAD_BEEF;
        @(negedge Clk);
        MemDataReady = 1'b0;
        @(negedge Clk);
        check("idle_mdr_busy", Busy, 1'b0);

        // Flush with ReadEnable in IDLE: no lookup, line gone afterwards
        ReadEnable  = 1'b1;
        Flush       = 1'b1;
        ReadAddress = 32'h1000;
        @(negedge Clk);
        ReadEnable = 1'b0;
        Flush      = 1'b0;
        check("flre_hits", HitCount, exp_hits);
        check("flre_misses", MissCount, exp_misses);
        check("flre_busy", Busy, 1'b0);
        access(32'h1000, 1'b0, -1);

        // Clean cache, then LRU ordering in set 0
        @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        access(32'h000, 1'b0, -1);
        access(32'h080, 1'b0, -1);
        access(32'h100, 1'b0, -1);
        access(32'h180, 1'b0, -1);
        access(32'h000, 1'b1, -1);
        access(32'h200, 1'b0, -1);
        access(32'h100, 1'b1, -1);
        access(32'h000, 1'b1, -1);
        access(32'h080, 1'b0, -1);
        access(32'h180, 1'b0, -1);

        // Flush during refill: early restart still delivered, line invalid
        access(32'h1000, 1'b0, 1);
        access(32'h1000, 1'b0, -1);
        access(32'h000, 1'b0, -1);

        // Counter saturation
        for (int i = 0; i < 12; i++)
            access(32'h1004, 1'b1, -1);
        access(32'h2000, 1'b0, -1);
        access(32'h3000, 1'b0, -1);
        access(32'h4000, 1'b0, -1);
        access(32'h5000, 1'b0, -1);

        // Reset between beats 2 and 3 of a refill
        @(negedge Clk);
        ReadEnable  = 1'b1;
        ReadAddress = 32'h1038;
        exp_q.push_back(mem_word(32'h1038));
        @(negedge Clk);
        ReadEnable = 1'b0;
        check("rm_req", MemReadRequest, 1'b1);
        for (int k = 0; k < 2; k++) begin
            MemDataReady = 1'b1;
            MemDataIn    = mem_word({ReadAddress[31:4], 2'(ReadAddress[3:2] + 2'(k)), 2'b00});
            @(negedge Clk);
        end
        MemDataReady = 1'b0;
        #1 ResetN = 1'b0;
        #1;
        check("rm_req_drop", MemReadRequest, 1'b0);
        check("rm_busy_drop", Busy, 1'b0);
        check("rm_hits", HitCount, 0);
        check("rm_misses", MissCount, 0);
        check("rm_ready_seen", exp_q.size(), 0);
        @(negedge Clk);
        ResetN     = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
        access(32'h1038, 1'b0, -1);
        access(32'h1030, 1'b1, -1);

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1);
    end

endmodule

// File: doc/ucsbece154_icache_cwf.md
Name: ucsbece154_icache_cwf

Overview:
Parametrised set-associative instruction cache. It sits between the fetch stage and the SDRAM controller and is the next generation of the team's instruction cache. New behaviour over the previous generation:
- critical-word-first refill with early restart
- true LRU replacement
- whole-cache Flush
- saturating hit/miss performance counters

Parameters:
NUM_SETS, 8, number of sets; power of 2, ≥2
NUM_WAYS, 4, ways per set; power of 2, ≥2
BLOCK_WORDS, 4, 32-bit words per line; power of 2, ≥2
WORD_SIZE, 32, instruction width; fixed at 32
CNT_WIDTH, 32, width of the performance counters

Ports:
Clk  in  1  clock, rising edge
ResetN  in  1  asynchronous, active-low reset
ReadEnable  in  1  fetch request, sampled in IDLE only
ReadAddress  in  32  byte address of the fetch; bits [1:0] ignored
Flush  in  1  invalidate all lines
Instruction  out  WORD_SIZE  fetched word, valid while Ready=1
Ready  out  1  one-cycle pulse: Instruction valid
Busy  out  1  refill in progress; core must hold its request
MemReadAddress  out  32  word-aligned address of the critical word
MemReadRequest  out  1  refill request, held high for the whole burst
MemDataIn  in  32  burst data
MemDataReady  in  1  MemDataIn valid this cycle
HitCount  out  CNT_WIDTH  saturating count of hits
MissCount  out  CNT_WIDTH  saturating count of misses

Behaviour:
- Address split: word offset = addr[OFF-1:2], where OFF = 2 + log2(BLOCK_WORDS). Set = next log2(NUM_SETS) bits. Tag = the remaining upper bits.
- Reset (ResetN=0, async): all outputs 0, all valid bits 0, LRU ages set so way i has age i, counters 0, state IDLE. Asserting reset mid-refill drops MemReadRequest and Busy immediately and abandons the burst.
- States: IDLE and FILL.
- IDLE, ReadEnable=1, hit:
  - next edge: Instruction=data, Ready=1.
  - hit way becomes MRU (age 0); ways younger than it age by 1.
  - HitCount increments.
  - Hit latency is 1 cycle; back-to-back hits give Ready every cycle.
- IDLE, ReadEnable=1, miss (next edge):
  - Busy=1, MemReadRequest=1, MemReadAddress={ReadAddress[31:2],2'b00}.
  - Latch set, tag and critical offset c.
  - Victim = lowest-index invalid way, else the way with age NUM_WAYS-1.
  - Victim valid bit cleared immediately.
  - MissCount increments; state becomes FILL.
- FILL, on the k-th MemDataReady (k=0..BLOCK_WORDS-1):
  - Word is written to offset (c+k) mod BLOCK_WORDS of the victim way (wrap order).
  - k=0 (early restart): next edge Instruction=MemDataIn, Ready=1.
  - k=BLOCK_WORDS-1, next edge:
    - tag written, valid=1, victim becomes MRU
    - MemReadRequest=0, Busy=0, state IDLE
  - Cycles without MemDataReady are stalls; the counter holds.
- While in FILL:
  - ReadEnable is ignored; no hit-under-miss.
  - Ready pulses exactly once per miss.
  - The first cycle after returning to IDLE accepts a new request.
- Flush:
  - In IDLE: all valid bits clear at the next edge; LRU ages reset. Flush has priority over a same-cycle ReadEnable: no lookup, no Ready, no counter change.
  - In FILL: recorded in a pending bit and applied on the edge the last word lands, so the just-filled line is also invalid. The early-restart Ready is still delivered.
- Counters saturate at all-ones and never wrap. They clear only on reset.
- MemDataReady while in IDLE is ignored.

Test Plan:
- Reset, then ReadEnable, ReadAddress=0x0000_1008 (set 0, offset 2):
  - next edge: MemReadRequest=1, MemReadAddress=0x0000_1008, Busy=1.
  - Memory returns words 0xA2,0xA3,0xA0,0xA1 over 4 MemDataReady cycles.
  - Ready=1 with Instruction=0xA2 one cycle after the first beat.
  - Busy=0 after the fourth beat. MissCount=1.
- After that fill, read 0x1000, 0x1004, 0x100C on consecutive cycles:
  - Ready every cycle with 0xA0, 0xA1, 0xA3.
  - no MemReadRequest; HitCount=3.
- LRU check:
  - Fill tags T0..T3 into set 0 (addresses 0x000, 0x080, 0x100, 0x180), then hit 0x000.
  - Miss on 0x200: victim is way 1 (T1).
  - Afterwards 0x000 still hits and 0x080 misses.
- Flush during FILL (asserted on the second beat):
  - Ready still pulses with the critical word.
  - Re-reading the same address afterwards misses (MissCount increments).
- Flush and ReadEnable together in IDLE:
  - no Ready, counters unchanged.
  - a subsequent read of a previously hit address misses.
- ResetN pulled low between beats 2 and 3:
  - MemReadRequest=0 and Busy=0 asynchronously; counters 0.
  - after release, a read of the same address misses.
